// File: rtl/updi_rx_deserializer.sv
// ============================================================================
// updi_rx_deserializer : UPDI receive path, 8E2 frames plus BREAK detection
// Revision 1.0
// ============================================================================
`default_nettype none

module updi_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       updi_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       busy
);

  localparam int            CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_CNT_HALF = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_BREAK  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, ln, ln_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          fe_q, fe_d;
  logic [7:0]    dout_q, dout_d;
  logic          dv_q, dv_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          brk_q, brk_d;
  logic          sample;

  assign sample = (cnt_q == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      ln      <= 1'b1;
      ln_q    <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      fe_q    <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      sync1_q <= updi_in;
      ln      <= sync1_q;
      ln_q    <= ln;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      fe_q    <= fe_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == S_IDLE || sample) ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    fe_d    = fe_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = 1'b0;

    // Dropping rx_en mid-frame discards everything, including a same-cycle STOP2 sample.
    if (state_q != S_IDLE && !rx_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_en && ln_q && !ln) begin
            state_d = S_START;
            cnt_d   = C_CNT_HALF;
            fe_d    = 1'b0;
          end
        end
        S_START: begin
          if (sample) begin
            state_d = ln ? S_IDLE : S_DATA;
            idx_d   = '0;
          end
        end
        S_DATA: begin
          if (sample) begin
            shift_d[idx_q] = ln;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          if (sample) begin
            par_d   = ln;
            state_d = S_STOP1;
          end
        end
        S_STOP1: begin
          if (sample) begin
            if (ln) begin
              state_d = S_STOP2;
            end else if (shift_q == 8'h00 && !par_q) begin
              // Line has been low for 11 bit times: treat as BREAK, not a byte.
              state_d = S_BREAK;
            end else begin
              fe_d    = 1'b1;
              state_d = S_STOP2;
            end
          end
        end
        S_STOP2: begin
          if (sample) begin
            ferr_d  = fe_q | ~ln;
            perr_d  = par_q ^ (^shift_q);
            dout_d  = shift_q;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BREAK: begin
          if (ln) begin
            brk_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_updi_rx_deserializer.sv
// ============================================================================
// tb_updi_rx_deserializer : directed self-checking bench, CLKS_PER_BIT = 8
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_updi_rx_deserializer;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       updi_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dv_cnt   = 0;
  int brk_cnt  = 0;
  int brk_cyc  = 0;
  int start_cyc;
  int rel_cyc;
  int base_dv;
  int base_brk;

  logic [7:0] dv_data [0:31];
  logic       dv_pe   [0:31];
  logic       dv_fe   [0:31];
  int         dv_cyc  [0:31];

  updi_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .updi_in    (updi_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output event at the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_data[dv_cnt[4:0]] = data_out;
      dv_pe[dv_cnt[4:0]]   = parity_err;
      dv_fe[dv_cnt[4:0]]   = frame_err;
      dv_cyc[dv_cnt[4:0]]  = cyc;
      dv_cnt               = dv_cnt + 1;
    end
    if (break_det) begin
      brk_cnt = brk_cnt + 1;
      brk_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    logic [11:0] f;
    f         = {s2, s1, p, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 12; i++) begin
      updi_in = f[i];
      repeat (CPB) @(negedge clk);
    end
    updi_in = 1'b1;
  endtask

  initial begin
    int lat;
    rst     = 1'b1;
    rx_en   = 1'b0;
    updi_in = 1'b1;
    idle(4);
    check("rst_data_out",   {24'd0, data_out}, 32'h00);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err",  {31'd0, frame_err}, 32'd0);
    check("rst_break_det",  {31'd0, break_det}, 32'd0);
    check("rst_busy",       {31'd0, busy}, 32'd0);
    rst   = 1'b0;
    rx_en = 1'b1;
    idle(4);

    // 0x55, correct parity 0, clean stops
    base_dv = dv_cnt;
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    idle(2 * CPB);
    check("f55_count", dv_cnt - base_dv, 1);
    check("f55_data",  {24'd0, dv_data[base_dv]}, 32'h55);
    check("f55_perr",  {31'd0, dv_pe[base_dv]}, 32'd0);
    check("f55_ferr",  {31'd0, dv_fe[base_dv]}, 32'd0);
    lat = dv_cyc[base_dv] - start_cyc;
    check("f55_latency_in_94_96", {31'd0, (lat >= 94 && lat <= 96)}, 32'd1);
    check("f55_busy_after", {31'd0, busy}, 32'd0);

    // 0x01 with wrong parity
    base_dv = dv_cnt;
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    idle(2 * CPB);
    check("f01_count", dv_cnt - base_dv, 1);
    check("f01_data",  {24'd0, dv_data[base_dv]}, 32'h01);
    check("f01_perr",  {31'd0, dv_pe[base_dv]}, 32'd1);
    check("f01_ferr",  {31'd0, dv_fe[base_dv]}, 32'd0);

    // 0xA5 with stop2 low, then recovery with 0x3C
    base_dv = dv_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(2 * CPB);
    check("fA5_count", dv_cnt - base_dv, 1);
    check("fA5_data",  {24'd0, dv_data[base_dv]}, 32'hA5);
    check("fA5_perr",  {31'd0, dv_pe[base_dv]}, 32'd0);
    check("fA5_ferr",  {31'd0, dv_fe[base_dv]}, 32'd1);
    base_dv = dv_cnt;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    idle(2 * CPB);
    check("f3C_count", dv_cnt - base_dv, 1);
    check("f3C_data",  {24'd0, dv_data[base_dv]}, 32'h3C);
    check("f3C_perr",  {31'd0, dv_pe[base_dv]}, 32'd0);
    check("f3C_ferr",  {31'd0, dv_fe[base_dv]}, 32'd0);

    // BREAK: 15 bit times low
    base_dv  = dv_cnt;
    base_brk = brk_cnt;
    updi_in  = 1'b0;
    idle(15 * CPB);
    updi_in  = 1'b1;
    rel_cyc  = cyc;
    idle(2 * CPB);
    check("brk_no_dv", dv_cnt - base_dv, 0);
    check("brk_count", brk_cnt - base_brk, 1);
    check("brk_delay_2_3", {31'd0, ((brk_cyc - rel_cyc) >= 2 && (brk_cyc - rel_cyc) <= 3)}, 32'd1);
    check("brk_busy_after", {31'd0, busy}, 32'd0);

    // 2-cycle glitch
    base_dv = dv_cnt;
    updi_in = 1'b0;
    idle(2);
    updi_in = 1'b1;
    idle(4);
    check("glitch_busy_mid", {31'd0, busy}, 32'd1);
    idle(6);
    check("glitch_busy_end", {31'd0, busy}, 32'd0);
    idle(CPB * 12);
    check("glitch_no_dv", dv_cnt - base_dv, 0);

    // Abort 0xFF during data bit 4
    base_dv  = dv_cnt;
    base_brk = brk_cnt;
    updi_in  = 1'b0;
    idle(CPB);
    updi_in  = 1'b1;
    idle(4 * CPB + 3);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rx_en = 1'b0;
    idle(1);
    check("abort_busy_after", {31'd0, busy}, 32'd0);
    idle(10 * CPB);
    check("abort_no_dv", dv_cnt - base_dv, 0);
    check("abort_no_brk", brk_cnt - base_brk, 0);
    check("abort_data_kept", {24'd0, data_out}, 32'h3C);
    rx_en = 1'b1;
    idle(4);

    // Back-to-back 0x00 then 0xFF
    base_dv  = dv_cnt;
    base_brk = brk_cnt;
    send_frame(8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    idle(2 * CPB);
    check("b2b_count", dv_cnt - base_dv, 2);
    check("b2b_data0", {24'd0, dv_data[base_dv]}, 32'h00);
    check("b2b_data1", {24'd0, dv_data[base_dv + 1]}, 32'hFF);
    check("b2b_errs0", {30'd0, dv_pe[base_dv], dv_fe[base_dv]}, 32'd0);
    check("b2b_errs1", {30'd0, dv_pe[base_dv + 1], dv_fe[base_dv + 1]}, 32'd0);
    check("b2b_spacing", dv_cyc[base_dv + 1] - dv_cyc[base_dv], 12 * CPB);
    check("b2b_no_brk", brk_cnt - base_brk, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
